// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for a 4:1 data mux. It grants one requester at a time,
// forwards that requester's data over valid/ready, and caps each grant at HOLD_MAX beats.
module mux4_rr_arbiter #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [3:0]            req,
   input  logic [4*DATA_W-1:0]   i,
   input  logic                  y_ready,
   output logic [3:0]            grant,
   output logic [1:0]            sel,
   output logic [DATA_W-1:0]     y,
   output logic                  y_valid,
   output logic                  busy
);

   localparam int unsigned CW = $clog2(HOLD_MAX) + 1;

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state_q, state_n;
   logic [3:0]      grant_n;
   logic [1:0]      sel_n;
   logic            busy_n;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_n;
   logic [1:0]      last_q, last_n;

   logic [DATA_W-1:0] slice [4];
   logic [1:0]        base;
   logic [1:0]        idx;
   logic [1:0]        win;
   logic              win_found;
   logic              xfer;
   logic              release_grant;

   always_comb begin
      for (int k = 0; k < 4; k++) slice[k] = i[k*DATA_W +: DATA_W];
   end

   // Data path is combinational from i so a beat is forwarded in the cycle it is offered.
   assign y       = (state_q == GRANT) ? slice[sel] : '0;
   assign y_valid = (state_q == GRANT) & req[sel];

   assign xfer          = y_valid & y_ready;
   assign release_grant = (state_q == GRANT) &&
                          (!req[sel] || (xfer && (beat_cnt_q == CW'(HOLD_MAX - 1))));

   // Scan starts after the current winner while releasing, else after the last winner.
   always_comb begin
      base      = (state_q == GRANT) ? sel : last_q;
      idx       = '0;
      win       = '0;
      win_found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = base + 2'(k);
         if (!win_found && req[idx]) begin
            win_found = 1'b1;
            win       = idx;
         end
      end
   end

   always_comb begin
      state_n    = state_q;
      grant_n    = grant;
      sel_n      = sel;
      busy_n     = busy;
      beat_cnt_n = beat_cnt_q;
      last_n     = last_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_n    = GRANT;
               grant_n    = 4'b0001 << win;
               sel_n      = win;
               busy_n     = 1'b1;
               beat_cnt_n = '0;
            end
         end
         GRANT: begin
            if (release_grant) begin
               last_n     = sel;
               beat_cnt_n = '0;
               if (win_found) begin
                  grant_n = 4'b0001 << win;
                  sel_n   = win;
               end else begin
                  state_n = IDLE;
                  grant_n = '0;
                  sel_n   = '0;
                  busy_n  = 1'b0;
               end
            end else if (xfer) begin
               beat_cnt_n = beat_cnt_q + CW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant      <= '0;
         sel        <= '0;
         busy       <= 1'b0;
         beat_cnt_q <= '0;
         last_q     <= 2'd3;
      end else begin
         state_q    <= state_n;
         grant      <= grant_n;
         sel        <= sel_n;
         busy       <= busy_n;
         beat_cnt_q <= beat_cnt_n;
         last_q     <= last_n;
      end
   end

endmodule
